// File: rtl/wb_div_initiator.sv
// wb_div_initiator
//   Wishbone initiator that runs one division on the serial-divider CSR block
//   for each accepted local request. The bus sequence is: write DIVIDEND,
//   write DIVISOR, write START, poll FINI until bit 0 is set, read QUOTIENT,
//   and optionally read REMAINDER. Every transfer is followed by one idle
//   cycle, because the responder ignores stb while its own ack is high.
//
//   Build option: define DIV_INIT_REM_RD_EN to add the REMAINDER read.
//   Without it, BASE+0x0C is never accessed and remainder_o is tied to 0.
//
// Ports
//   clk_i, reset_ni              clock, asynchronous active-low reset
//   req_i                        start request (sampled only while idle)
//   dividend_i, divisor_i        operands, captured when req_i is accepted
//   busy_o                       high from acceptance until done_o/err_o
//   done_o, err_o                1-cycle completion / abort pulses
//   err_code_o                   01 ack timeout, 10 poll limit (held)
//   quotient_o, remainder_o      last results read (held)
//   wbm_*                        Wishbone initiator port
module wb_div_initiator #(
  parameter int             WBW         = 32,
  parameter int             XLEN        = 32,
  parameter logic [WBW-1:0] BASE_ADR    = 32'h3000_0000,
  parameter int             ACK_TIMEOUT = 64,
  parameter int             POLL_LIMIT  = 1024
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              req_i,
  input  logic [XLEN-1:0]   dividend_i,
  input  logic [XLEN-1:0]   divisor_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [1:0]        err_code_o,
  output logic [XLEN-1:0]   quotient_o,
  output logic [XLEN-1:0]   remainder_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [WBW/8-1:0]  wbm_sel_o,
  output logic [WBW-1:0]    wbm_adr_o,
  output logic [WBW-1:0]    wbm_dat_o,
  input  logic              wbm_ack_i,
  input  logic [WBW-1:0]    wbm_dat_i
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int PW = $clog2(POLL_LIMIT + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(ACK_TIMEOUT - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_LIMIT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_DVD, S_WR_DVS, S_WR_START, S_RD_FINI,
    S_RD_QUO, S_RD_REM, S_GAP, S_DONE, S_ERR
  } state_t;

  state_t            state_q, state_d, ret_q, ret_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [PW-1:0]     poll_q, poll_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [1:0]        code_q, code_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   dvd_q, dvd_d, dvs_q, dvs_d;
  logic              cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [WBW-1:0]    adr_q, adr_d, dat_q, dat_d;
`ifdef DIV_INIT_REM_RD_EN
  logic [XLEN-1:0]   rem_q, rem_d;
`endif

  function automatic logic [WBW-1:0] zext(input logic [XLEN-1:0] v);
    zext = '0;
    zext[XLEN-1:0] = v;
  endfunction

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    tmo_d   = tmo_q;
    poll_d  = poll_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    quo_d   = quo_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
`ifdef DIV_INIT_REM_RD_EN
    rem_d   = rem_q;
`endif
    cyc_d   = 1'b0;
    stb_d   = 1'b0;
    we_d    = 1'b0;
    adr_d   = '0;
    dat_d   = '0;

    case (state_q)
      // done_q/err_q are high in the first idle cycle; a request seen then is dropped
      S_IDLE: if (req_i && !done_q && !err_q) begin
        state_d = S_WR_DVD;
        busy_d  = 1'b1;
        code_d  = 2'b00;
        poll_d  = '0;
        dvd_d   = dividend_i;
        dvs_d   = divisor_i;
      end
      S_WR_DVD:   if (wbm_ack_i) begin state_d = S_GAP; ret_d = S_WR_DVS;   end
      S_WR_DVS:   if (wbm_ack_i) begin state_d = S_GAP; ret_d = S_WR_START; end
      S_WR_START: if (wbm_ack_i) begin state_d = S_GAP; ret_d = S_RD_FINI;  end
      S_RD_FINI: if (wbm_ack_i) begin
        if (wbm_dat_i[0]) begin
          state_d = S_GAP;
          ret_d   = S_RD_QUO;
        end else if (poll_q == POLL_LAST) begin
          state_d = S_ERR;
          code_d  = 2'b10;
        end else begin
          state_d = S_GAP;
          ret_d   = S_RD_FINI;
          poll_d  = poll_q + PW'(1);
        end
      end
      S_RD_QUO: if (wbm_ack_i) begin
        quo_d   = wbm_dat_i[XLEN-1:0];
        state_d = S_GAP;
`ifdef DIV_INIT_REM_RD_EN
        ret_d   = S_RD_REM;
`else
        ret_d   = S_DONE;
`endif
      end
`ifdef DIV_INIT_REM_RD_EN
      S_RD_REM: if (wbm_ack_i) begin
        rem_d   = wbm_dat_i[XLEN-1:0];
        state_d = S_GAP;
        ret_d   = S_DONE;
      end
`endif
      S_GAP:  state_d = ret_q;
      S_DONE: begin done_d = 1'b1; busy_d = 1'b0; state_d = S_IDLE; end
      S_ERR:  begin err_d  = 1'b1; busy_d = 1'b0; state_d = S_IDLE; end
      default: state_d = S_IDLE;
    endcase

    // Ack watchdog overrides the transfer outcome; moving to ERR drops stb below.
    if (stb_q && !wbm_ack_i) begin
      if (tmo_q == TMO_LAST) begin
        state_d = S_ERR;
        code_d  = 2'b01;
        tmo_d   = '0;
      end else begin
        tmo_d   = tmo_q + TW'(1);
      end
    end else begin
      tmo_d = '0;
    end

    // Bus signals are registered from the next state so they are valid on
    // entry and remain constant for as long as the transfer state is held.
    case (state_d)
      S_WR_DVD:   begin cyc_d = 1'b1; stb_d = 1'b1; we_d = 1'b1; adr_d = BASE_ADR;              dat_d = zext(dvd_d); end
      S_WR_DVS:   begin cyc_d = 1'b1; stb_d = 1'b1; we_d = 1'b1; adr_d = BASE_ADR + WBW'('h04); dat_d = zext(dvs_d); end
      S_WR_START: begin cyc_d = 1'b1; stb_d = 1'b1; we_d = 1'b1; adr_d = BASE_ADR + WBW'('h18); dat_d = WBW'(1);    end
      S_RD_FINI:  begin cyc_d = 1'b1; stb_d = 1'b1; adr_d = BASE_ADR + WBW'('h14); end
      S_RD_QUO:   begin cyc_d = 1'b1; stb_d = 1'b1; adr_d = BASE_ADR + WBW'('h08); end
      S_RD_REM:   begin cyc_d = 1'b1; stb_d = 1'b1; adr_d = BASE_ADR + WBW'('h0C); end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      ret_q   <= S_IDLE;
      tmo_q   <= '0;
      poll_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
      quo_q   <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      tmo_q   <= tmo_d;
      poll_q  <= poll_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
      quo_q   <= quo_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
    end
  end

  // Operand holding registers: only read after being loaded on acceptance.
  always_ff @(posedge clk_i) begin
    dvd_q <= dvd_d;
    dvs_q <= dvs_d;
  end

`ifdef DIV_INIT_REM_RD_EN
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) rem_q <= '0;
    else           rem_q <= rem_d;
  end
  assign remainder_o = rem_q;
`else
  assign remainder_o = '0;
`endif

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign err_code_o = code_q;
  assign quotient_o = quo_q;
  assign wbm_cyc_o  = cyc_q;
  assign wbm_stb_o  = stb_q;
  assign wbm_we_o   = we_q;
  assign wbm_sel_o  = '1;
  assign wbm_adr_o  = adr_q;
  assign wbm_dat_o  = dat_q;

endmodule

// File: tb/tb_wb_div_initiator.sv
// tb_wb_div_initiator
//   Directed bench for wb_div_initiator with a zero-wait divider responder
//   model (combinational ack, programmable FINI delay and a selectable
//   address that is never acknowledged) plus a Wishbone protocol monitor.
//   Honours DIV_INIT_REM_RD_EN for the remainder-read expectations.
module tb_wb_div_initiator;

  localparam logic [31:0] BASE = 32'h3000_0000;

`ifdef DIV_INIT_REM_RD_EN
  localparam bit REM_EN = 1'b1;
`else
  localparam bit REM_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        req_i = 1'b0;
  logic [31:0] dividend_i = '0;
  logic [31:0] divisor_i = '0;
  logic        busy_o, done_o, err_o;
  logic [1:0]  err_code_o;
  logic [31:0] quotient_o, remainder_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  wb_div_initiator #(.POLL_LIMIT(8)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .req_i(req_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o),
    .quotient_o(quotient_o), .remainder_o(remainder_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- responder model ----------------
  logic [31:0] m_dvd = '0, m_dvs = '0;
  int          m_polls = 0;
  int          fini_on = 1;
  logic [31:0] nack_adr = 32'hFFFF_FFFF;
  int          log_n = 0, start_cnt = 0, dvd_cnt = 0, rem_seen = 0, fini_reads = 0, done_cnt = 0;
  logic [31:0] log_adr [0:63];
  logic [31:0] log_dat [0:63];
  logic        log_we  [0:63];
  logic [31:0] off;

  always @* begin
    off       = wbm_adr_o - BASE;
    wbm_ack_i = wbm_cyc_o && wbm_stb_o && (wbm_adr_o != nack_adr);
    case (off)
      32'h14:  wbm_dat_i = (m_polls + 1 >= fini_on) ? 32'd1 : 32'd0;
      32'h08:  wbm_dat_i = (m_dvs != 0) ? m_dvd / m_dvs : 32'hFFFF_FFFF;
      32'h0C:  wbm_dat_i = (m_dvs != 0) ? m_dvd % m_dvs : m_dvd;
      default: wbm_dat_i = 32'h0;
    endcase
  end

  always @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      m_polls <= 0;
    end else if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
      log_adr[log_n % 64] <= wbm_adr_o;
      log_dat[log_n % 64] <= wbm_dat_o;
      log_we[log_n % 64]  <= wbm_we_o;
      log_n <= log_n + 1;
      if (wbm_we_o && off == 32'h00) begin m_dvd <= wbm_dat_o; dvd_cnt <= dvd_cnt + 1; end
      if (wbm_we_o && off == 32'h04) m_dvs <= wbm_dat_o;
      if (wbm_we_o && off == 32'h18) begin start_cnt <= start_cnt + 1; m_polls <= 0; end
      if (!wbm_we_o && off == 32'h14) begin m_polls <= m_polls + 1; fini_reads <= fini_reads + 1; end
    end
  end

  always @(negedge clk_i) if (wbm_cyc_o && wbm_stb_o && off == 32'h0C) rem_seen <= rem_seen + 1;
  always @(negedge clk_i) if (done_o) done_cnt <= done_cnt + 1;

  // ---------------- protocol monitor ----------------
  logic        p_valid = 1'b0, p_stb = 1'b0, p_ack = 1'b0, p_we = 1'b0;
  logic [31:0] p_adr = '0, p_dat = '0;

  always @(negedge clk_i) begin
    if (!reset_ni) begin
      p_valid = 1'b0;
    end else begin
      if (wbm_stb_o && !wbm_cyc_o) chk("proto_stb_without_cyc", 32'(wbm_cyc_o), 32'd1);
      if (wbm_stb_o) chk("proto_sel", 32'(wbm_sel_o), 32'hF);
      if (p_valid && p_stb && !p_ack && wbm_stb_o) begin
        if (wbm_adr_o !== p_adr) chk("proto_adr_stable", wbm_adr_o, p_adr);
        if (wbm_dat_o !== p_dat) chk("proto_dat_stable", wbm_dat_o, p_dat);
        if (wbm_we_o  !== p_we)  chk("proto_we_stable", 32'(wbm_we_o), 32'(p_we));
      end
      if (p_valid && p_stb && p_ack) chk("proto_idle_gap", 32'(wbm_stb_o), 32'd0);
      p_valid = 1'b1;
      p_stb   = wbm_stb_o;
      p_ack   = wbm_ack_i;
      p_adr   = wbm_adr_o;
      p_dat   = wbm_dat_o;
      p_we    = wbm_we_o;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_req(input logic [31:0] a, input logic [31:0] b);
    dividend_i = a;
    divisor_i  = b;
    req_i      = 1'b1;
    tick();
    req_i      = 1'b0;
  endtask

  // Returns edges counted after the accepting edge until done_o or err_o.
  task automatic wait_end(output int n);
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      n++;
      if (done_o || err_o) return;
    end
    chk("wait_end_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_stb_at(input logic [31:0] adr);
    for (int i = 0; i < 100; i++) begin
      if (wbm_stb_o && wbm_adr_o == adr) return;
      tick();
    end
    chk("wait_stb_timeout", wbm_adr_o, adr);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=stuck expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base, s0, s1, cnt;

    // Reset state
    repeat (3) tick();
    chk("rst_cyc", 32'(wbm_cyc_o), 0);
    chk("rst_stb", 32'(wbm_stb_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_code", 32'(err_code_o), 0);
    chk("rst_quo", quotient_o, 0);
    chk("rst_rem", remainder_o, 0);
    chk("rst_adr", wbm_adr_o, 0);
    reset_ni = 1'b1;
    repeat (2) tick();

    // 100/4 with FINI set on the third poll
    fini_on = 3;
    base = log_n;
    do_req(100, 4);
    chk("t1_busy_after_accept", 32'(busy_o), 1);
    wait_end(n);
    chk("t1_done", 32'(done_o), 1);
    chk("t1_err", 32'(err_o), 0);
    chk("t1_busy", 32'(busy_o), 0);
    chk("t1_quo", quotient_o, 25);
    chk("t1_nxfers", 32'(log_n - base), REM_EN ? 32'd8 : 32'd7);
    chk("t1_x0_adr", log_adr[base],     32'h3000_0000);
    chk("t1_x0_we",  32'(log_we[base]), 1);
    chk("t1_x0_dat", log_dat[base],     100);
    chk("t1_x1_adr", log_adr[base + 1], 32'h3000_0004);
    chk("t1_x1_dat", log_dat[base + 1], 4);
    chk("t1_x2_adr", log_adr[base + 2], 32'h3000_0018);
    chk("t1_x2_we",  32'(log_we[base + 2]), 1);
    for (int k = 3; k < 6; k++) begin
      chk("t1_poll_adr", log_adr[base + k], 32'h3000_0014);
      chk("t1_poll_we",  32'(log_we[base + k]), 0);
    end
    chk("t1_quo_adr", log_adr[base + 6], 32'h3000_0008);
    if (REM_EN) chk("t1_rem_adr", log_adr[base + 7], 32'h3000_000C);
    tick();
    chk("t1_done_pulse", 32'(done_o), 0);

    // Latency with FINI on first poll; 47/11 = 4 rem 3
    fini_on = 1;
    do_req(47, 11);
    wait_end(n);
    chk("t2_done", 32'(done_o), 1);
    chk("t2_latency_cycle", 32'(n + 2), REM_EN ? 32'd15 : 32'd13);
    chk("t2_quo", quotient_o, 4);
    chk("t2_rem", remainder_o, REM_EN ? 32'd3 : 32'd0);
    tick();

    // Request while busy and request in the done cycle are both ignored
    fini_on = 3;
    s0 = dvd_cnt;
    s1 = done_cnt;
    do_req(300, 4);
    repeat (4) tick();
    do_req(999, 1);
    wait_end(n);
    chk("t3_done", 32'(done_o), 1);
    dividend_i = 7;
    divisor_i  = 7;
    req_i      = 1'b1;
    tick();
    req_i      = 1'b0;
    chk("t3_req_on_done_ignored", 32'(busy_o), 0);
    chk("t3_no_stb", 32'(wbm_stb_o), 0);
    repeat (20) tick();
    chk("t3_one_sequence", 32'(dvd_cnt - s0), 1);
    chk("t3_one_done", 32'(done_cnt - s1), 1);
    chk("t3_quo", quotient_o, 75);

    // DIVISOR write never acknowledged
    nack_adr = 32'h3000_0004;
    s0 = start_cnt;
    do_req(10, 2);
    wait_stb_at(32'h3000_0004);
    cnt = 0;
    while (wbm_stb_o && cnt < 200) begin
      cnt++;
      tick();
    end
    chk("t4_stb_cycles", 32'(cnt), 64);
    chk("t4_cyc_dropped", 32'(wbm_cyc_o), 0);
    chk("t4_err_not_yet", 32'(err_o), 0);
    tick();
    chk("t4_err", 32'(err_o), 1);
    chk("t4_code", 32'(err_code_o), 1);
    chk("t4_busy", 32'(busy_o), 0);
    chk("t4_no_start", 32'(start_cnt - s0), 0);
    tick();
    chk("t4_err_pulse", 32'(err_o), 0);
    chk("t4_code_held", 32'(err_code_o), 1);
    nack_adr = 32'hFFFF_FFFF;

    // FINI stuck at 0 hits the poll limit of 8
    fini_on = 1000;
    s0 = fini_reads;
    s1 = start_cnt;
    do_req(9, 3);
    wait_end(n);
    chk("t5_err", 32'(err_o), 1);
    chk("t5_done", 32'(done_o), 0);
    chk("t5_code", 32'(err_code_o), 2);
    chk("t5_busy", 32'(busy_o), 0);
    chk("t5_fini_reads", 32'(fini_reads - s0), 8);
    chk("t5_one_start", 32'(start_cnt - s1), 1);
    tick();
    fini_on = 1;
    do_req(9, 3);
    chk("t5_code_cleared", 32'(err_code_o), 0);
    chk("t5_busy_again", 32'(busy_o), 1);
    wait_end(n);
    chk("t5_done_after", 32'(done_o), 1);
    chk("t5_quo", quotient_o, 3);
    tick();

    // Asynchronous reset while a FINI read is on the bus
    fini_on = 1000;
    do_req(50, 5);
    wait_stb_at(32'h3000_0014);
    #2;
    reset_ni = 1'b0;
    #1;
    chk("t6_cyc_async", 32'(wbm_cyc_o), 0);
    chk("t6_stb_async", 32'(wbm_stb_o), 0);
    chk("t6_busy_async", 32'(busy_o), 0);
    repeat (2) tick();
    reset_ni = 1'b1;
    tick();
    fini_on = 1;
    do_req(50, 5);
    wait_end(n);
    chk("t6_done", 32'(done_o), 1);
    chk("t6_quo", quotient_o, 10);
    tick();

    chk("rem_access_seen", 32'(rem_seen != 0), 32'(REM_EN));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
